// File: rtl/mod13_count_checker.sv
// Passive monitor for the mod-MOD up/down counter: tracks a reference model,
// flags count mismatches, illegal loads and wrap events, with saturating tallies.
module mod13_count_checker #(
    parameter int unsigned MOD    = 13,
    parameter int unsigned CW     = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned WRAP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              load,
    input  logic [CW-1:0]     data_in,
    input  logic [CW-1:0]     count,
    output logic [CW-1:0]     exp_count,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              load_range_err,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] dn_wraps,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StTrack  = 2'd1,
        StResync = 2'd2,
        StBad    = 2'd3
    } state_e;

    localparam logic [CW-1:0] MaxVal = CW'(MOD - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      exp_q, exp_d;
    logic               mismatch_q, mismatch_d;
    logic               sticky_q, sticky_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               lre_q, lre_d;
    logic               wup_q, wup_d;
    logic               wdn_q, wdn_d;
    logic [WRAP_W-1:0]  up_wraps_q, up_wraps_d;
    logic [WRAP_W-1:0]  dn_wraps_q, dn_wraps_d;

    logic          compare_en;
    logic          hit;
    logic          load_ok;
    logic          base_oor;
    logic [CW-1:0] base;

    assign compare_en = (state_q == StInit) || (state_q == StTrack);
    assign hit        = (count == exp_q);
    // On a miss (or while resyncing) the model follows the observed count.
    assign base       = (compare_en && hit) ? exp_q : count;
    assign base_oor   = 32'(base) >= MOD;
    assign load_ok    = 32'(data_in) < MOD;

    always_comb begin
        state_d    = StTrack;
        exp_d      = exp_q;
        mismatch_d = 1'b0;
        lre_d      = 1'b0;
        wup_d      = 1'b0;
        wdn_d      = 1'b0;
        if (state_q == StBad) begin
            state_d = StInit;
            exp_d   = '0;
        end else begin
            mismatch_d = compare_en && !hit;
            if (load) begin
                if (load_ok) begin
                    exp_d = data_in;
                end else begin
                    lre_d   = 1'b1;
                    state_d = StResync;
                end
            end else if (mode) begin
                if (base == MaxVal) begin
                    exp_d = '0;
                    wup_d = 1'b1;
                end else if (base_oor) begin
                    exp_d = '0;
                end else begin
                    exp_d = base + CW'(1);
                end
            end else begin
                if (base == '0) begin
                    exp_d = MaxVal;
                    wdn_d = 1'b1;
                end else if (base_oor) begin
                    exp_d = MaxVal;
                end else begin
                    exp_d = base - CW'(1);
                end
            end
        end

        sticky_d   = sticky_q | mismatch_d | lre_d;
        err_cnt_d  = (mismatch_d && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
        up_wraps_d = (wup_d && (up_wraps_q != '1)) ? up_wraps_q + WRAP_W'(1) : up_wraps_q;
        dn_wraps_d = (wdn_d && (dn_wraps_q != '1)) ? dn_wraps_q + WRAP_W'(1) : dn_wraps_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
            lre_q      <= 1'b0;
            wup_q      <= 1'b0;
            wdn_q      <= 1'b0;
            up_wraps_q <= '0;
            dn_wraps_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            err_cnt_q  <= err_cnt_d;
            lre_q      <= lre_d;
            wup_q      <= wup_d;
            wdn_q      <= wdn_d;
            up_wraps_q <= up_wraps_d;
            dn_wraps_q <= dn_wraps_d;
        end
    end

    assign exp_count      = exp_q;
    assign mismatch       = mismatch_q;
    assign err_sticky     = sticky_q;
    assign err_cnt        = err_cnt_q;
    assign load_range_err = lre_q;
    assign wrap_up        = wup_q;
    assign wrap_dn        = wdn_q;
    assign up_wraps       = up_wraps_q;
    assign dn_wraps       = dn_wraps_q;
    assign state          = state_q;

endmodule

// File: doc/mod13_count_checker.md
Name: mod13_count_checker

Overview:
- Passive downstream monitor of the mod-13 up/down counter.
- Shares the counter's clock and reset, and snoops the same control inputs (mode, load, data_in) and the counter's count output.
- Runs its own reference model of the counter and reports count mismatches, wrap events and illegal load values.
- Intended to sit beside the counter in the design and to feed its status to a scoreboard or status register.

Parameters:
- MOD, 13, counter modulus; legal count values are 0..MOD-1.
- CW, 4, width of count and data_in; must satisfy 2**CW >= MOD.
- ERR_W, 8, width of the saturating mismatch counter.
- WRAP_W, 16, width of each saturating wrap counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  counter direction as driven to the counter; 1 = up, 0 = down.
- load  in  1  counter load strobe as driven to the counter.
- data_in  in  CW  counter load value.
- count  in  CW  counter output.
- exp_count  out  CW  model's expected count for the current cycle.
- mismatch  out  1  one-cycle pulse: count differed from exp_count in the previous cycle.
- err_sticky  out  1  set on any mismatch or illegal load; cleared only by rst.
- err_cnt  out  ERR_W  number of mismatches, saturating.
- load_range_err  out  1  one-cycle pulse: load occurred with data_in >= MOD in the previous cycle.
- wrap_up  out  1  one-cycle pulse: model stepped MOD-1 -> 0 by counting up.
- wrap_dn  out  1  one-cycle pulse: model stepped 0 -> MOD-1 by counting down.
- up_wraps  out  WRAP_W  saturating count of wrap_up events.
- dn_wraps  out  WRAP_W  saturating count of wrap_dn events.
- state  out  2  FSM state, for debug.

Behaviour:
- All outputs are registered. On any clk edge with rst=1, every output is 0 and the FSM goes to INIT. rst takes priority over everything, including mid-operation.
- FSM states:
  - INIT (0): first cycle after rst falls. The counter has just been reset, so exp_count=0 is compared against count, then go to TRACK.
  - TRACK (1): normal compare-and-update.
  - RESYNC (2): entered after an illegal load. No compare this cycle; the model adopts the observed count; return to TRACK.
  - State 3 is unused; if reached, go to INIT.
- Compare: in INIT and TRACK, every cycle with rst=0 samples (count != exp_count). The result appears on mismatch at the next edge (one-cycle latency).
- Model update at each edge (rst=0, state not RESYNC), with base = exp_count on a compare hit, or count on a mismatch (auto-resync, so a single fault does not cascade):
  - load=1 and data_in < MOD: exp_count <= data_in.
  - load=1 and data_in >= MOD: load_range_err <= 1, err_sticky <= 1, next state RESYNC. exp_count is don't-care until resynced.
  - load=0, mode=1: exp_count <= (base == MOD-1) ? 0 : base+1; wrap_up <= (base == MOD-1).
  - load=0, mode=0: exp_count <= (base == 0) ? MOD-1 : base-1; wrap_dn <= (base == 0).
  - load has priority over mode. A load of 0 or MOD-1 never raises a wrap pulse.
- In RESYNC: exp_count <= model update applied to the observed count, using that cycle's load, mode and data_in. No compare and no mismatch.
- Counters:
  - err_cnt increments with each mismatch pulse and holds at all-ones.
  - up_wraps and dn_wraps increment with their pulses and hold at all-ones.
- Any mismatch also sets err_sticky.
- Out-of-range count (count >= MOD) is a mismatch by construction, since exp_count is always < MOD after INIT.
- Simultaneous mismatch and wrap in one cycle: both pulses are legal together. The wrap is judged on base, i.e. the observed count.

Test Plan:
- Reset, then mode=1, load=0 for 14 cycles with a correct counter -> mismatch never set; wrap_up pulses exactly once, the cycle after count=12; up_wraps=1; exp_count sequence 0,1,...,12,0,1.
- load=1, data_in=5 for one cycle, then mode=0 for 7 cycles -> exp_count 5,4,3,2,1,0,12; wrap_dn pulses once after count=0; dn_wraps=1; err_cnt=0.
- Force count=7 while exp_count=3 for one cycle -> mismatch pulses one cycle later; err_cnt=1; err_sticky=1. Next with mode=1, exp_count=8 (resynced). No further mismatches.
- load=1, data_in=14 -> load_range_err pulses next cycle; state=2 for one cycle, then 1; err_sticky=1; no mismatch in the RESYNC cycle.
- ERR_W=2 build, inject 5 mismatches -> err_cnt saturates at 3.
- Assert rst mid-count (count=9, err_sticky=1) -> all outputs 0 next edge; after rst falls, state=INIT, then TRACK; counting resumes cleanly from 0.
